tff_toggle_gen: RTL and testbench
=================================

Name: tff_toggle_gen

Overview:
- Upstream stage of the T flip-flop: generates the `t` toggle-enable that the TFF consumes.
- Two request sources:
  - manual path: a noisy asynchronous request line, synchronised, debounced and edge-detected into a single one-cycle toggle pulse;
  - burst path: a programmable burst of N toggle pulses separated by G idle cycles.
- Output `t` is registered and drives the TFF `t` input directly. Both blocks share the same `clk`.

Parameters:
- CNT_W, 8, width of burst-length and gap counters.
- DEB_CYC, 4, consecutive equal synchronised samples required before the debounced level changes (>=1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, one clock; reset is synchronous and active-high.
- req  in  1  asynchronous manual toggle request (button-like, may bounce).
- start  in  1  one-cycle burst start strobe, synchronous to clk.
- burst_len  in  CNT_W  number of toggle pulses in a burst; sampled only on an accepted start.
- gap  in  CNT_W  number of t=0 cycles between consecutive burst pulses; sampled only on an accepted start.
- t  out  1  registered toggle enable to the TFF.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse marking burst completion.

Behaviour:
- Reset: when rst=1 at a clk edge, the next state is as follows.
  - t=0, busy=0, done=0.
  - FSM=IDLE, all counters=0.
  - Sync flops and debounced level=0; debounce counter=0.
  - Applies mid-burst: the burst is abandoned and no done pulse is issued.
- Manual path:
  - req passes through 2 flops, then the debouncer.
  - The debounced level changes only after DEB_CYC consecutive cycles of sync output differing from the current level. Any mismatch-free sample resets the count.
  - A rising edge of the debounced level while FSM=IDLE and start=0 produces t=1 for exactly one cycle.
  - The same rising edge while busy, or coincident with an accepted start, is dropped. It is not queued.
  - A falling edge produces nothing.
  - Latency from a clean req rise to t=1 is 2 + DEB_CYC + 1 cycles.
- Burst FSM states: IDLE, PULSE, GAP, DONE.
  - IDLE, start=1, burst_len!=0: latch rem=burst_len and gap_l=gap; next state PULSE.
  - IDLE, start=1, burst_len=0: next state DONE; no t pulse.
  - IDLE, start=0: stay in IDLE.
  - PULSE: t=1 for this cycle; rem decrements.
    - rem==1 → DONE.
    - else gap_l==0 → PULSE (t stays high on consecutive cycles).
    - else load gcnt=gap_l and go to GAP.
  - GAP: t=0; gcnt decrements; when gcnt==1 the next state is PULSE.
  - DONE: t=0, done=1 for one cycle; next state IDLE.
  - start outside IDLE is ignored.
- Timing:
  - Accepted start at edge k gives the first t=1 in the cycle after edge k (busy=1 from the same cycle).
  - Total burst duration is N + (N-1)*G cycles, plus 1 DONE cycle.
  - busy=1 in PULSE, GAP and DONE.
- Arithmetic:
  - All counters are unsigned CNT_W bits.
  - burst_len=2^CNT_W-1 is legal.
  - No wrap-around is possible: counters only decrement from nonzero values.
- t is the OR of the manual pulse register and the FSM PULSE state, both registered. They are mutually exclusive by construction.

Decomposition:
- Package tff_pkg:
  - state enum {IDLE, PULSE, GAP, DONE} (2-bit);
  - default CNT_W and DEB_CYC constants.
- One sub-module, tff_req_debounce:
  - ports: clk, rst, req_async in; level and rise_pulse out;
  - contains the 2-flop synchroniser, the DEB_CYC counter and the edge detect.
- The top level holds the FSM, the counters and the t/done/busy registers.

Test Plan:
- Reset: assert rst 3 cycles mid-burst (burst_len=5, gap=2, after 2nd pulse) → next cycle t=0, busy=0, done=0; no further pulses; done never pulses.
- Burst: burst_len=3, gap=2, start at cycle 10 → t=1 in cycles 11, 14, 17; done=1 in cycle 18; busy=1 in cycles 11–18; a downstream TFF q toggles 3 times (odd, so final q inverted).
- Back-to-back pulses: burst_len=4, gap=0 → t high in cycles 11–14 continuously; done in cycle 15. burst_len=0 → done in cycle 11 with t never high.
- Debounce (DEB_CYC=4): req toggles 1/0/1 with 1-cycle glitches, then holds high → exactly one t pulse, 7 cycles after the stable rise reaches the pins. A 3-cycle high glitch → no pulse.
- Collisions: start pulsed again during a burst → ignored, pulse count unchanged. Clean req rise during busy → dropped; no t pulse after done.
- Long burst: burst_len=255, gap=1 → exactly 255 t pulses, 509 busy cycles before DONE, done once.

Source files
------------

// File: rtl/tff_pkg.sv
// Shared types and default parameters for the TFF toggle-enable generator.
package tff_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned DEF_CNT_W   = 8;
   localparam int unsigned DEF_DEB_CYC = 4;

endpackage

// File: rtl/tff_toggle_gen_if.sv
// Burst control and toggle-output bundle between a controller and tff_toggle_gen.
interface tff_toggle_gen_if
   import tff_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
);
   logic             start;
   logic [CNT_W-1:0] burst_len;
   logic [CNT_W-1:0] gap;
   logic             t;
   logic             busy;
   logic             done;

   modport master (
      output start, burst_len, gap,
      input  t, busy, done
   );

   modport slave (
      input  start, burst_len, gap,
      output t, busy, done
   );
endinterface

// File: rtl/tff_req_debounce.sv
// Manual request path: 2-flop synchroniser, DEB_CYC-sample debouncer and
// registered one-cycle pulse on each rising edge of the debounced level.
module tff_req_debounce
   import tff_pkg::*;
#(
   parameter int unsigned DEB_CYC = DEF_DEB_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic req_async,
   output logic level,
   output logic rise_pulse
);

   localparam int unsigned CW = $clog2(DEB_CYC) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         level      <= 1'b0;
         rise_pulse <= 1'b0;
         cnt        <= '0;
      end else begin
         s1         <= req_async;
         s2         <= s1;
         rise_pulse <= 1'b0;
         if (s2 != level) begin
            // The DEB_CYC-th consecutive differing sample commits the new level.
            if (cnt == LAST) begin
               level      <= s2;
               cnt        <= '0;
               rise_pulse <= s2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/tff_toggle_gen.sv
// Generates the registered toggle enable t for a downstream TFF from a
// debounced manual request and a programmable pulse-burst FSM.
module tff_toggle_gen
   import tff_pkg::*;
#(
   parameter int unsigned CNT_W   = DEF_CNT_W,
   parameter int unsigned DEB_CYC = DEF_DEB_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   tff_toggle_gen_if.slave   bus
);

   state_t           state, state_n;
   logic [CNT_W-1:0] rem, rem_n;
   logic [CNT_W-1:0] gcnt, gcnt_n;
   logic [CNT_W-1:0] gap_l, gap_n;
   logic             man_n;
   logic             deb_rise;
   logic             t_r, busy_r, done_r;

   tff_req_debounce #(
      .DEB_CYC (DEB_CYC)
   ) u_deb (
      .clk        (clk),
      .rst        (rst),
      .req_async  (req),
      .level      (),
      .rise_pulse (deb_rise)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rem    <= '0;
         gcnt   <= '0;
         gap_l  <= '0;
         t_r    <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         state  <= state_n;
         rem    <= rem_n;
         gcnt   <= gcnt_n;
         gap_l  <= gap_n;
         t_r    <= man_n | (state_n == PULSE);
         busy_r <= (state_n != IDLE);
         done_r <= (state_n == DONE);
      end
   end

   always_comb begin
      state_n = state;
      rem_n   = rem;
      gcnt_n  = gcnt;
      gap_n   = gap_l;
      man_n   = 1'b0;

      case (state)
         IDLE: begin
            // Start always wins over a coincident manual edge, which is dropped.
            man_n = deb_rise & ~bus.start;
            if (bus.start) begin
               if (bus.burst_len != '0) begin
                  rem_n   = bus.burst_len;
                  gap_n   = bus.gap;
                  state_n = PULSE;
               end else begin
                  state_n = DONE;
               end
            end
         end
         PULSE: begin
            rem_n = rem - 1'b1;
            if (rem == CNT_W'(1)) begin
               state_n = DONE;
            end else if (gap_l != '0) begin
               gcnt_n  = gap_l;
               state_n = GAP;
            end
         end
         GAP: begin
            gcnt_n = gcnt - 1'b1;
            if (gcnt == CNT_W'(1)) begin
               state_n = PULSE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.t    = t_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;

endmodule

// File: tb/tb_tff_toggle_gen.sv
// Directed self-checking bench for tff_toggle_gen (CNT_W=8, DEB_CYC=4).
module tb_tff_toggle_gen;
   import tff_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req = 1'b0;
   logic q   = 1'b0;

   int unsigned total = 0;
   int unsigned bad   = 0;

   tff_toggle_gen_if #(.CNT_W(8)) bus ();

   tff_toggle_gen #(
      .CNT_W   (8),
      .DEB_CYC (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .req (req),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Downstream TFF driven by t.
   always @(posedge clk) begin
      if (rst) q <= 1'b0;
      else if (bus.t) q <= ~q;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fire(input logic [7:0] len, input logic [7:0] g);
      bus.start     = 1'b1;
      bus.burst_len = len;
      bus.gap       = g;
      tick();
      bus.start     = 1'b0;
   endtask

   // Cycle i (1-based after the start edge) expects bit i-1 of each mask.
   task automatic expect_seq(input string tag, input int unsigned n,
                             input logic [31:0] tm, input logic [31:0] dm, input logic [31:0] bm);
      for (int unsigned i = 0; i < n; i++) begin
         chk($sformatf("%s.t%0d", tag, i + 1), 32'(bus.t), 32'(tm[i]));
         chk($sformatf("%s.done%0d", tag, i + 1), 32'(bus.done), 32'(dm[i]));
         chk($sformatf("%s.busy%0d", tag, i + 1), 32'(bus.busy), 32'(bm[i]));
         tick();
      end
   endtask

   initial begin
      int unsigned pulses, dones, busyc;

      bus.start     = 1'b0;
      bus.burst_len = '0;
      bus.gap       = '0;

      // Reset state
      tick(); tick();
      chk("rst.t", 32'(bus.t), 0);
      chk("rst.busy", 32'(bus.busy), 0);
      chk("rst.done", 32'(bus.done), 0);
      rst = 1'b0;
      repeat (3) tick();

      // len=3 gap=2: t at 1,4,7; done at 8; busy 1..8
      fire(8'd3, 8'd2);
      expect_seq("b32", 10, 32'h49, 32'h80, 32'hFF);
      chk("b32.q", 32'(q), 1);

      // len=4 gap=0: t 1..4 continuous, done at 5
      fire(8'd4, 8'd0);
      expect_seq("b40", 7, 32'h0F, 32'h10, 32'h1F);

      // len=0: done only
      fire(8'd0, 8'd5);
      expect_seq("b0", 3, 32'h0, 32'h1, 32'h1);

      // Reset mid-burst after 2nd pulse
      fire(8'd5, 8'd2);
      expect_seq("rb", 4, 32'h9, 32'h0, 32'hF);
      rst = 1'b1;
      tick();
      chk("rb.t", 32'(bus.t), 0);
      chk("rb.busy", 32'(bus.busy), 0);
      chk("rb.done", 32'(bus.done), 0);
      tick(); tick();
      rst = 1'b0;
      pulses = 0; dones = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.t) pulses++;
         if (bus.done) dones++;
         tick();
      end
      chk("rb.pulses", pulses, 0);
      chk("rb.dones", dones, 0);

      // Bouncy req then stable high: one pulse 7 cycles after stable rise
      req = 1'b1; tick();
      req = 1'b0; tick();
      req = 1'b1; tick();
      req = 1'b0; tick();
      req = 1'b1;
      tick();
      for (int unsigned i = 1; i <= 12; i++) begin
         chk($sformatf("deb.t%0d", i), 32'(bus.t), 32'(i == 7));
         tick();
      end
      req = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.t) pulses++;
         tick();
      end
      chk("deb.fall", pulses, 0);

      // 3-cycle glitch: no pulse
      req = 1'b1; repeat (3) tick();
      req = 1'b0;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         if (bus.t) pulses++;
         tick();
      end
      chk("glitch", pulses, 0);

      // Re-start during burst is ignored
      fire(8'd3, 8'd2);
      pulses = 0; dones = 0;
      for (int i = 1; i <= 14; i++) begin
         bus.start     = (i == 2);
         bus.burst_len = 8'd7;
         if (bus.t) pulses++;
         if (bus.done) dones++;
         tick();
      end
      bus.start = 1'b0;
      chk("restart.pulses", pulses, 3);
      chk("restart.dones", dones, 1);

      // Clean req rise during busy is dropped
      req = 1'b1;
      fire(8'd3, 8'd2);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.t) pulses++;
         tick();
      end
      chk("busyreq.pulses", pulses, 3);
      req = 1'b0;
      repeat (20) tick();

      // Long burst len=255 gap=1
      fire(8'd255, 8'd1);
      pulses = 0; dones = 0; busyc = 0;
      for (int i = 0; i < 600; i++) begin
         if (bus.t) pulses++;
         if (bus.busy && !bus.done) busyc++;
         if (bus.done) dones++;
         tick();
      end
      chk("long.pulses", pulses, 255);
      chk("long.busy", busyc, 509);
      chk("long.dones", dones, 1);
      chk("long.idle", 32'(bus.busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
